// File: rtl/path_probe_pkg.sv
// rtl/path_probe_pkg.sv - shared state and path-select definitions for path_probe_ctrl
package path_probe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam logic [2:0] SEL_A   = 3'd0;
  localparam logic [2:0] SEL_B   = 3'd1;
  localparam logic [2:0] SEL_C   = 3'd2;
  localparam logic [2:0] SEL_D   = 3'd3;
  localparam logic [2:0] SEL_SRC = 3'd4;
  localparam logic [2:0] SEL_MAX = 3'd4;

  // a..d pattern held before launch: every input high except the one under test
  function automatic logic [3:0] setup_drive(input logic [2:0] s);
    logic [3:0] m;
    m = 4'h0;
    if (s < SEL_SRC) m = ~(4'b0001 << s[1:0]);
    return m;
  endfunction

endpackage

// File: rtl/path_probe_ctrl_sync2.sv
// rtl/path_probe_ctrl_sync2.sv - two-flop single-bit synchronizer for sensed cell outputs
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/path_probe_ctrl.sv
// rtl/path_probe_ctrl.sv - launch/sense path-delay sequencer for the AND-tree cell
// Optional PATH_PROBE_SYNC_EN: synchronize out_i/dest_i and remove the 2-cycle sync latency from delay.
module path_probe_ctrl
  import path_probe_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255,
  parameter int SETTLE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       sel,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             d_o,
  output logic [3:0]       src_o,
  input  logic             out_i,
  input  logic             dest_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] delay,
  output logic             timeout,
  output logic             err
);

  localparam int SC_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  state_t           state;
  logic [2:0]       sel_r;
  logic [CNT_W-1:0] cnt;
  logic [SC_W-1:0]  sc;
  logic             out_s;
  logic             dest_s;
  logic             sense;
  logic             sel_ok;
  logic [CNT_W-1:0] rep;
  logic [3:0]       abcd;

`ifdef PATH_PROBE_SYNC_EN
  sync2 u_sync_out  (.clk(clk), .rst(rst), .d(out_i),  .q(out_s));
  sync2 u_sync_dest (.clk(clk), .rst(rst), .d(dest_i), .q(dest_s));
  assign rep = (cnt >= CNT_W'(2)) ? cnt - CNT_W'(2) : '0;
`else
  assign out_s  = out_i;
  assign dest_s = dest_i;
  assign rep    = cnt;
`endif

  assign sel_ok = (sel_r <= SEL_MAX);
  assign sense  = (sel_r == SEL_SRC) ? dest_s : out_s;

  // An invalid sel still spends one busy cycle in SETUP (with no drives) so done
  // lands two cycles after start, then reports err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_r   <= '0;
      cnt     <= '0;
      sc      <= '0;
      delay   <= '0;
      timeout <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel_r   <= sel;
            sc      <= '0;
            timeout <= 1'b0;
            err     <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (!sel_ok) begin
            delay <= '0;
            err   <= 1'b1;
            state <= REPORT;
          end else if (sc == SC_W'(SETTLE - 1)) begin
            if (sense) begin
              delay <= '0;
              err   <= 1'b1;
              state <= REPORT;
            end else begin
              cnt   <= '0;
              state <= MEASURE;
            end
          end else begin
            sc <= sc + 1'b1;
          end
        end
        MEASURE: begin
          if (sense) begin
            delay <= rep;
            state <= REPORT;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            delay   <= CNT_W'(TIMEOUT);
            timeout <= 1'b1;
            state   <= REPORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    abcd  = 4'h0;
    src_o = 4'h0;
    case (state)
      SETUP:   if (sel_ok) abcd = setup_drive(sel_r);
      MEASURE: begin
        if (sel_r == SEL_SRC) src_o = 4'hF;
        else                  abcd  = 4'hF;
      end
      default: abcd = 4'h0;
    endcase
  end

  assign {d_o, c_o, b_o, a_o} = abcd;
  assign busy = (state != IDLE);
  assign done = (state == REPORT);

endmodule

// File: tb/tb_path_probe_ctrl.sv
// tb/tb_path_probe_ctrl.sv - self-checking bench for path_probe_ctrl with a behavioural cell model
module tb_path_probe_ctrl;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 255;
  localparam int SETTLE  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       sel;
  logic             a_o, b_o, c_o, d_o;
  logic [3:0]       src_o;
  logic             out_i, dest_i;
  logic             busy, done;
  logic [CNT_W-1:0] delay;
  logic             timeout, err;

  int errors = 0;
  int checks = 0;

  int         r_dones, r_lat;
  logic [7:0] r_delay, r_setup, r_meas, r_after, r_any;
  logic       r_to, r_err, r_busy1;
  bit         r_launched;

  path_probe_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o), .src_o(src_o),
    .out_i(out_i), .dest_i(dest_i),
    .busy(busy), .done(done), .delay(delay), .timeout(timeout), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] drv();
    return {src_o, d_o, c_o, b_o, a_o};
  endfunction

  // Cell model: sense output rises d cycles after the launch is seen (d<0: never).
  task automatic do_run(input logic [2:0] s, input int d, input bit stuck, input bit poke);
    int m;
    int post;
    logic [7:0] dv;
    r_dones = 0; r_lat = -1; r_launched = 0; m = 0; post = -1;
    r_setup = 8'h00; r_meas = 8'h00; r_after = 8'hFF; r_any = 8'h00;
    r_delay = 8'h00; r_to = 1'b0; r_err = 1'b0; r_busy1 = 1'b0;
    if (stuck) begin
      if (s == 3'd4) dest_i = 1'b1;
      else           out_i  = 1'b1;
    end
    sel = s;
    start = 1'b1;
    for (int cyc = 1; cyc <= SETTLE + TIMEOUT + 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) r_busy1 = busy;
      if (cyc == 1 || (poke && cyc == SETTLE + 4)) start = 1'b0;
      if (poke && cyc == SETTLE + 3) begin
        start = 1'b1;
        sel = 3'd6;
      end
      dv = drv();
      if (r_lat < 0) r_any = r_any | dv;
      if (cyc == SETTLE) r_setup = dv;
      if (done) begin
        r_dones++;
        if (r_lat < 0) begin
          r_lat = cyc; r_delay = delay; r_to = timeout; r_err = err; post = cyc;
        end
      end
      if (post >= 0 && cyc == post + 1) r_after = dv;
      if (!r_launched && (s == 3'd4 ? (src_o == 4'hF) : (s < 3'd4 && dv[s] == 1'b1))) begin
        r_launched = 1; m = 0; r_meas = dv;
      end else if (r_launched) begin
        m++;
      end
      if (r_launched && d >= 0 && m == d) begin
        if (s == 3'd4) dest_i = 1'b1;
        else           out_i  = 1'b1;
      end
      if (post >= 0 && cyc >= post + 3) break;
    end
    start = 1'b0;
    out_i = 1'b0;
    dest_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_valid(input string name, input logic [2:0] s, input int d);
    bit         exp_to;
    int         exp_dl;
    logic [7:0] exp_setup, exp_meas;
    exp_to = (d < 0) || (d > TIMEOUT);
    exp_dl = exp_to ? TIMEOUT : d;
    exp_setup = (s < 3'd4) ? 8'(15 - (1 << s)) : 8'h00;
    exp_meas  = (s < 3'd4) ? 8'h0F : 8'hF0;
    checks++; if (r_dones !== 1) begin errors++; $display("FAIL %s done_count got=%0d exp=1", name, r_dones); end
    checks++; if (r_delay !== 8'(exp_dl)) begin errors++; $display("FAIL %s delay got=%0d exp=%0d", name, r_delay, exp_dl); end
    checks++; if (r_to !== exp_to) begin errors++; $display("FAIL %s timeout got=%0b exp=%0b", name, r_to, exp_to); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL %s err got=%0b exp=0", name, r_err); end
    checks++; if (r_lat !== SETTLE + 2 + exp_dl) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", name, r_lat, SETTLE + 2 + exp_dl); end
    checks++; if (r_setup !== exp_setup) begin errors++; $display("FAIL %s setup_drive got=%h exp=%h", name, r_setup, exp_setup); end
    checks++; if (r_meas !== exp_meas) begin errors++; $display("FAIL %s measure_drive got=%h exp=%h", name, r_meas, exp_meas); end
    checks++; if (r_after !== 8'h00) begin errors++; $display("FAIL %s drive_after got=%h exp=00", name, r_after); end
    checks++; if (r_busy1 !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got=%0b exp=1", name, r_busy1); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 3'd0; out_i = 1'b0; dest_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (drv() !== 8'h00) begin errors++; $display("FAIL reset drives got=%h exp=00", drv()); end
    checks++; if ({busy, done, timeout, err} !== 4'b0000) begin errors++; $display("FAIL reset flags got=%b exp=0000", {busy, done, timeout, err}); end
    checks++; if (delay !== 8'd0) begin errors++; $display("FAIL reset delay got=%0d exp=0", delay); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_paths();
    do_run(3'd0, 9, 0, 0);  check_valid("path_a_9", 3'd0, 9);
    do_run(3'd2, 11, 0, 0); check_valid("path_c_11", 3'd2, 11);
    do_run(3'd4, 32, 0, 0); check_valid("path_src_32", 3'd4, 32);
    do_run(3'd3, 0, 0, 0);  check_valid("path_d_0", 3'd3, 0);
  endtask

  task automatic test_timeout();
    do_run(3'd1, -1, 0, 0);  check_valid("timeout_never", 3'd1, -1);
    do_run(3'd3, 255, 0, 0); check_valid("rise_at_limit", 3'd3, 255);
    do_run(3'd0, 256, 0, 0); check_valid("rise_past_limit", 3'd0, 256);
  endtask

  task automatic test_invalid_sel();
    do_run(3'd6, -1, 0, 0);
    checks++; if (r_dones !== 1) begin errors++; $display("FAIL invalid done_count got=%0d exp=1", r_dones); end
    checks++; if (r_lat !== 2) begin errors++; $display("FAIL invalid latency got=%0d exp=2", r_lat); end
    checks++; if ({r_err, r_to} !== 2'b10) begin errors++; $display("FAIL invalid err_timeout got=%b exp=10", {r_err, r_to}); end
    checks++; if (r_delay !== 8'd0) begin errors++; $display("FAIL invalid delay got=%0d exp=0", r_delay); end
    checks++; if (r_any !== 8'h00) begin errors++; $display("FAIL invalid drive_activity got=%h exp=00", r_any); end
  endtask

  task automatic test_stuck_sense();
    do_run(3'd1, -1, 1, 0);
    checks++; if (r_dones !== 1) begin errors++; $display("FAIL stuck done_count got=%0d exp=1", r_dones); end
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL stuck err got=%0b exp=1", r_err); end
    checks++; if (r_launched) begin errors++; $display("FAIL stuck launched got=1 exp=0"); end
    checks++; if (r_lat !== SETTLE + 1) begin errors++; $display("FAIL stuck latency got=%0d exp=%0d", r_lat, SETTLE + 1); end
    do_run(3'd4, -1, 1, 0);
    checks++; if ({r_err, r_launched} !== 2'b10) begin errors++; $display("FAIL stuck_dest err_launch got=%b exp=10", {r_err, r_launched}); end
  endtask

  task automatic test_start_while_busy();
    do_run(3'd0, 5, 0, 1);
    check_valid("start_while_busy", 3'd0, 5);
  endtask

  task automatic test_reset_mid_measure();
    int n;
    sel = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE + 3) @(negedge clk);
    checks++; if (drv() !== 8'h0F || busy !== 1'b1) begin errors++; $display("FAIL midreset in_measure drives=%h busy=%0b exp=0f,1", drv(), busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset busy_done got=%b exp=00", {busy, done}); end
    checks++; if (drv() !== 8'h00) begin errors++; $display("FAIL midreset drives got=%h exp=00", drv()); end
    checks++; if (delay !== 8'd0) begin errors++; $display("FAIL midreset delay got=%0d exp=0", delay); end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 20) out_i = 1'b1;
      if (done || busy) n++;
    end
    out_i = 1'b0;
    checks++; if (n !== 0) begin errors++; $display("FAIL midreset activity_after got=%0d exp=0", n); end
  endtask

  task automatic test_random();
    logic [2:0] s;
    int d;
    for (int i = 0; i < 10; i++) begin
      s = 3'($urandom_range(4, 0));
      d = int'($urandom_range(60, 0));
      do_run(s, d, 0, 0);
      check_valid($sformatf("random_%0d_sel%0d_d%0d", i, s, d), s, d);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 3'd0; out_i = 1'b0; dest_i = 1'b0;
    test_reset();
    test_paths();
    test_timeout();
    test_invalid_sel();
    test_stuck_sense();
    test_start_while_busy();
    test_reset_mid_measure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
